// File: rtl/bist_fail_logger.sv
// bist_fail_logger: captures BIST fail events {addr, exp, act} into a small
// first-word-fall-through FIFO, keeps per-session fail statistics and lets
// the host drain the log through a valid/ready read port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no session active; fail strobes ignored
// LOGGING | session active; every fail strobe is counted and logged
// DONE    | BIST finished; fails ignored, log still readable
module bist_fail_logger #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 4,
    parameter int LOG_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              session_start,
    input  logic                              fail,
    input  logic [ADDR_WIDTH-1:0]             fail_addr,
    input  logic [WORD_WIDTH-1:0]             exp_data,
    input  logic [WORD_WIDTH-1:0]             act_data,
    input  logic                              test_done,
    input  logic                              rd_ready,
    output logic                              rd_valid,
    output logic [ADDR_WIDTH+2*WORD_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]              fail_count,
    output logic [ADDR_WIDTH-1:0]             first_fail_addr,
    output logic                              any_fail,
    output logic                              overflow,
    output logic                              log_done
);

    localparam int DATA_W = ADDR_WIDTH + 2 * WORD_WIDTH;
    localparam int PTR_W  = $clog2(LOG_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOGGING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] last_data;

    logic full, empty, capture, pop, push_ok, drop;

    assign empty = (occ == '0);
    assign full  = (occ == OCC_W'(LOG_DEPTH));

    // A session_start in the same cycle wins over both capture and pop,
    // since the log is being cleared anyway.
    assign capture = (state_q == LOGGING) && fail && !session_start;
    assign pop     = !empty && rd_ready && !session_start;
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign rd_valid = !empty;
    // Empty log presents the most recently popped word rather than stale array contents.
    assign rd_data  = empty ? last_data : mem[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d  = state_q;
        log_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (session_start) state_d = LOGGING;
            end
            LOGGING: begin
                if (session_start)  state_d = LOGGING;
                else if (test_done) state_d = DONE;
            end
            DONE: begin
                log_done = 1'b1;
                if (session_start) state_d = LOGGING;
            end
            default: state_d = IDLE;
        endcase
    end

    // Log storage; no reset needed since pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr] <= {fail_addr, exp_data, act_data};
        end
    end

    // FIFO pointers, occupancy and the last-popped word.
    always_ff @(posedge clk) begin
        if (!rst || session_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            last_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_data <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Session statistics; counted for every captured fail, logged or dropped.
    always_ff @(posedge clk) begin
        if (!rst || session_start) begin
            fail_count      <= '0;
            first_fail_addr <= '0;
            any_fail        <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            if (capture) begin
                if (fail_count != '1) fail_count <= fail_count + CNT_WIDTH'(1);
                any_fail <= 1'b1;
                if (!any_fail) first_fail_addr <= fail_addr;
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: reset, basic logging, overflow,
// full-FIFO push/pop, done/restart and mid-session reset.
module tb_bist_fail_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        session_start;
    logic        fail;
    logic [7:0]  fail_addr;
    logic [3:0]  exp_data;
    logic [3:0]  act_data;
    logic        test_done;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] fail_count;
    logic [7:0]  first_fail_addr;
    logic        any_fail;
    logic        overflow;
    logic        log_done;

    int vectors    = 0;
    int miscompares = 0;

    bist_fail_logger dut (
        .clk             (clk),
        .rst             (rst),
        .session_start   (session_start),
        .fail            (fail),
        .fail_addr       (fail_addr),
        .exp_data        (exp_data),
        .act_data        (act_data),
        .test_done       (test_done),
        .rd_ready        (rd_ready),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .any_fail        (any_fail),
        .overflow        (overflow),
        .log_done        (log_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        session_start = 1'b1;
        tick();
        session_start = 1'b0;
    endtask

    task automatic do_fail(input logic [7:0] a, input logic [3:0] e, input logic [3:0] x);
        fail = 1'b1; fail_addr = a; exp_data = e; act_data = x;
        tick();
        fail = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        do_fail(8'h10, 4'h3, 4'h1);
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        vectors++; if (rd_data !== 16'h0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
        vectors++; if (fail_count !== 16'd0) begin miscompares++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
        vectors++; if (first_fail_addr !== 8'h0) begin miscompares++; $display("FAIL reset_first_addr got %h want 00", first_fail_addr); end
        vectors++; if (any_fail !== 1'b0) begin miscompares++; $display("FAIL reset_any_fail got %0b want 0", any_fail); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        vectors++; if (log_done !== 1'b0) begin miscompares++; $display("FAIL reset_log_done got %0b want 0", log_done); end
    endtask

    task automatic test_basic();
        start_session();
        do_fail(8'h05, 4'hA, 4'h8);
        do_fail(8'h7F, 4'h5, 4'h4);
        tick();
        vectors++; if (fail_count !== 16'd2) begin miscompares++; $display("FAIL basic_count got %0d want 2", fail_count); end
        vectors++; if (first_fail_addr !== 8'h05) begin miscompares++; $display("FAIL basic_first got %h want 05", first_fail_addr); end
        vectors++; if (any_fail !== 1'b1) begin miscompares++; $display("FAIL basic_any got %0b want 1", any_fail); end
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %0b want 1", rd_valid); end
        vectors++; if (rd_data !== 16'h05A8) begin miscompares++; $display("FAIL basic_head got %h want 05a8", rd_data); end
        pop_one();
        vectors++; if (rd_data !== 16'h7F54) begin miscompares++; $display("FAIL basic_second got %h want 7f54", rd_data); end
        pop_one();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty got %0b want 0", rd_valid); end
        vectors++; if (rd_data !== 16'h7F54) begin miscompares++; $display("FAIL basic_hold got %h want 7f54", rd_data); end
        pop_one();
        vectors++; if (rd_data !== 16'h7F54) begin miscompares++; $display("FAIL basic_empty_pop got %h want 7f54", rd_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] a;
        start_session();
        for (int i = 0; i < 20; i++) begin
            a = 8'(i);
            do_fail(a, a[3:0], ~a[3:0]);
        end
        vectors++; if (fail_count !== 16'd20) begin miscompares++; $display("FAIL ovf_count got %0d want 20", fail_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        vectors++; if (first_fail_addr !== 8'h00) begin miscompares++; $display("FAIL ovf_first got %h want 00", first_fail_addr); end
        for (int i = 0; i < 16; i++) begin
            a = 8'(i);
            vectors++; if (rd_valid !== 1'b1 || rd_data !== {a, a[3:0], ~a[3:0]}) begin
                miscompares++; $display("FAIL ovf_drain%0d got v=%0b %h want v=1 %h", i, rd_valid, rd_data, {a, a[3:0], ~a[3:0]});
            end
            pop_one();
        end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %0b want 0", rd_valid); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] a;
        start_session();
        for (int i = 0; i < 16; i++) do_fail(8'h80 + 8'(i), 4'h0, 4'hF);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf_pre got %0b want 0", overflow); end
        fail = 1'b1; fail_addr = 8'h99; exp_data = 4'h6; act_data = 4'h2; rd_ready = 1'b1;
        tick();
        fail = 1'b0; rd_ready = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_ovf_post got %0b want 0", overflow); end
        vectors++; if (fail_count !== 16'd17) begin miscompares++; $display("FAIL full_count got %0d want 17", fail_count); end
        for (int i = 1; i < 16; i++) begin
            a = 8'h80 + 8'(i);
            vectors++; if (rd_valid !== 1'b1 || rd_data !== {a, 4'h0, 4'hF}) begin
                miscompares++; $display("FAIL full_drain%0d got v=%0b %h want v=1 %h", i, rd_valid, rd_data, {a, 4'h0, 4'hF});
            end
            pop_one();
        end
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'h9962) begin miscompares++; $display("FAIL full_last got v=%0b %h want v=1 9962", rd_valid, rd_data); end
        pop_one();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL full_empty got %0b want 0", rd_valid); end
    endtask

    task automatic test_done_restart();
        start_session();
        fail = 1'b1; fail_addr = 8'h33; exp_data = 4'hC; act_data = 4'hD; test_done = 1'b1;
        tick();
        fail = 1'b0; test_done = 1'b0;
        vectors++; if (log_done !== 1'b1) begin miscompares++; $display("FAIL done_flag got %0b want 1", log_done); end
        vectors++; if (fail_count !== 16'd1) begin miscompares++; $display("FAIL done_count got %0d want 1", fail_count); end
        do_fail(8'h44, 4'h1, 4'h0);
        vectors++; if (fail_count !== 16'd1) begin miscompares++; $display("FAIL done_ignore got %0d want 1", fail_count); end
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 16'h33CD) begin miscompares++; $display("FAIL done_head got v=%0b %h want v=1 33cd", rd_valid, rd_data); end
        pop_one();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL done_empty got %0b want 0", rd_valid); end
        do_fail(8'h21, 4'h2, 4'h3);
        vectors++; if (log_done !== 1'b1 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL done_hold got done=%0b v=%0b want 1 0", log_done, rd_valid); end
        session_start = 1'b1; fail = 1'b1; fail_addr = 8'h55;
        tick();
        session_start = 1'b0; fail = 1'b0;
        vectors++; if (fail_count !== 16'd0) begin miscompares++; $display("FAIL restart_count got %0d want 0", fail_count); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL restart_valid got %0b want 0", rd_valid); end
        vectors++; if (any_fail !== 1'b0) begin miscompares++; $display("FAIL restart_any got %0b want 0", any_fail); end
        vectors++; if (log_done !== 1'b0) begin miscompares++; $display("FAIL restart_done got %0b want 0", log_done); end
        do_fail(8'h66, 4'h7, 4'h6);
        vectors++; if (fail_count !== 16'd1 || first_fail_addr !== 8'h66) begin miscompares++; $display("FAIL restart_log got cnt=%0d first=%h want 1 66", fail_count, first_fail_addr); end
    endtask

    task automatic test_reset_mid();
        start_session();
        for (int i = 0; i < 5; i++) do_fail(8'h40 + 8'(i), 4'h9, 4'h1);
        vectors++; if (fail_count !== 16'd5) begin miscompares++; $display("FAIL mid_count_pre got %0d want 5", fail_count); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %0b want 0", rd_valid); end
        vectors++; if (fail_count !== 16'd0 || any_fail !== 1'b0) begin miscompares++; $display("FAIL mid_stats got cnt=%0d any=%0b want 0 0", fail_count, any_fail); end
        do_fail(8'h77, 4'h1, 4'h2);
        vectors++; if (fail_count !== 16'd0 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_idle got cnt=%0d v=%0b want 0 0", fail_count, rd_valid); end
    endtask

    initial begin
        rst = 1'b0; session_start = 1'b0; fail = 1'b0; fail_addr = '0;
        exp_data = '0; act_data = '0; test_done = 1'b0; rd_ready = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_done_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
